ibex_pext_alu: RTL and testbench



---
 rtl/ibex_pext_alu_if.sv | 72 +++++++
 rtl/ibex_pext_alu.sv | 167 ++++++++++++++++
 tb/tb_ibex_pext_alu.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pext_alu_if.sv
// Type packages and the EX-stage bus for the packed-SIMD (Zpn) execution unit.
//
// ibex_pkg       : scalar ALU and multdiv operator encodings
// ibex_pkg_pext  : packed-SIMD operator encodings
// ibex_pext_alu_if
//   slave  : the execution unit (consumes operands, drives result/imd_val)
//   master : the EX stage / core side
// Signals: operator selects, mult_en/ready handshake, imd_val_q/d/we,
//          operand_a/b/rd, imm_val, adder_result, result, valid, set_ov,
//          comparison_result.

package ibex_pkg;
  typedef enum logic [6:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLT, ALU_SLTU, ZPN_INSTR
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM
  } md_op_e;
endpackage

package ibex_pkg_pext;
  typedef enum logic [3:0] {
    ZPN_ADD16, ZPN_SUB16, ZPN_ADD8, ZPN_SUB8, ZPN_RADD16, ZPN_KADD16,
    ZPN_KSUB16, ZPN_SRA16, ZPN_SLL16, ZPN_SMMWB, ZPN_CRAS16
  } zpn_op_e;
endpackage

interface ibex_pext_alu_if;
  ibex_pkg_pext::zpn_op_e zpn_operator_i;
  logic                   zpn_instr_i;
  ibex_pkg::alu_op_e      alu_operator_i;
  ibex_pkg::md_op_e       multdiv_operator_i;
  logic [1:0]             signed_mode_i;
  logic                   div_en_i;
  logic                   div_sel_i;
  logic                   data_ind_timing_i;
  logic                   multdiv_sel_i;
  logic                   mult_sel_i;
  logic                   mult_en_i;
  logic                   multdiv_ready_id_i;
  logic [1:0][33:0]       imd_val_q_i;
  logic [1:0][33:0]       imd_val_d_o;
  logic [1:0]             imd_val_we_o;
  logic [31:0]            operand_a_i;
  logic [31:0]            operand_b_i;
  logic [31:0]            operand_rd_i;
  logic [4:0]             imm_val_i;
  logic [31:0]            adder_result_o;
  logic [31:0]            result_o;
  logic                   valid_o;
  logic                   set_ov_o;
  logic                   comparison_result_o;

  modport slave (
    input  zpn_operator_i, zpn_instr_i, alu_operator_i, multdiv_operator_i,
           signed_mode_i, div_en_i, div_sel_i, data_ind_timing_i,
           multdiv_sel_i, mult_sel_i, mult_en_i, multdiv_ready_id_i,
           imd_val_q_i, operand_a_i, operand_b_i, operand_rd_i, imm_val_i,
    output imd_val_d_o, imd_val_we_o, adder_result_o, result_o, valid_o,
           set_ov_o, comparison_result_o
  );

  modport master (
    output zpn_operator_i, zpn_instr_i, alu_operator_i, multdiv_operator_i,
           signed_mode_i, div_en_i, div_sel_i, data_ind_timing_i,
           multdiv_sel_i, mult_sel_i, mult_en_i, multdiv_ready_id_i,
           imd_val_q_i, operand_a_i, operand_b_i, operand_rd_i, imm_val_i,
    input  imd_val_d_o, imd_val_we_o, adder_result_o, result_o, valid_o,
           set_ov_o, comparison_result_o
  );
endinterface

// File: rtl/ibex_pext_alu.sv
// Packed-SIMD (Zpn subset) execution unit beside the base ALU / multdiv.
// Single-cycle 16/8-bit lane ops, immediate lane shifts, scalar add/sub/slt,
// and a two-cycle SMMWB multiply that parks its low partial product in the
// core's imd_val[0] register.
//
// Ports: clk_i, rst_ni (async, active low), bus (ibex_pext_alu_if.slave).
// Build option: IBEX_PEXT_SAT_EN enables KADD16/KSUB16 saturation and
// set_ov_o; without it those ops decode as unsupported (result 0).

module ibex_pext_lane16 (
  input  ibex_pkg_pext::zpn_op_e i_op,
  input  logic [15:0]            i_a,
  input  logic [15:0]            i_b,
  input  logic [3:0]             i_sh,
  output logic [15:0]            o_res,
  output logic                   o_ov
);
  import ibex_pkg_pext::*;

  // 17-bit sign-extended sum/difference: bit 16 is the true sign
  logic [16:0] w_sum, w_dif;
  assign w_sum = {i_a[15], i_a} + {i_b[15], i_b};
  assign w_dif = {i_a[15], i_a} - {i_b[15], i_b};

`ifdef IBEX_PEXT_SAT_EN
  // Overflow when the 17-bit sign disagrees with bit 15; clip toward the sign
  function automatic logic [16:0] sat16(input logic [16:0] s);
    if (s[16] != s[15]) return {1'b1, (s[16] ? 16'h8000 : 16'h7fff)};
    return {1'b0, s[15:0]};
  endfunction
`endif

  always_comb begin
    o_res = '0;
    o_ov  = 1'b0;
    case (i_op)
      ZPN_ADD16:  o_res = w_sum[15:0];
      ZPN_SUB16:  o_res = w_dif[15:0];
      ZPN_RADD16: o_res = w_sum[16:1];
`ifdef IBEX_PEXT_SAT_EN
      ZPN_KADD16: {o_ov, o_res} = sat16(w_sum);
      ZPN_KSUB16: {o_ov, o_res} = sat16(w_dif);
`endif
      ZPN_SRA16:  o_res = $signed(i_a) >>> i_sh;
      ZPN_SLL16:  o_res = i_a << i_sh;
      default:    ;
    endcase
  end

  logic unused_lane;
  assign unused_lane = w_dif[16];
endmodule

module ibex_pext_alu (
  input  logic            clk_i,
  input  logic            rst_ni,
  ibex_pext_alu_if.slave  bus
);
  import ibex_pkg::*;
  import ibex_pkg_pext::*;

  typedef enum logic {IDLE, STEP1} mult_state_e;
  mult_state_e mult_state_q;

  logic [31:0] w_a, w_b;
  assign w_a = bus.operand_a_i;
  assign w_b = bus.operand_b_i;

  // 16-bit lanes
  logic [1:0][15:0] w_l16;
  logic [1:0]       w_ov16;
  for (genvar g = 0; g < 2; g++) begin : g_lane16
    ibex_pext_lane16 u_lane (
      .i_op  (bus.zpn_operator_i),
      .i_a   (w_a[16*g +: 16]),
      .i_b   (w_b[16*g +: 16]),
      .i_sh  (bus.imm_val_i[3:0]),
      .o_res (w_l16[g]),
      .o_ov  (w_ov16[g])
    );
  end

  // 8-bit lanes
  logic [3:0][7:0] w_add8, w_sub8;
  for (genvar g = 0; g < 4; g++) begin : g_lane8
    assign w_add8[g] = w_a[8*g +: 8] + w_b[8*g +: 8];
    assign w_sub8[g] = w_a[8*g +: 8] - w_b[8*g +: 8];
  end

  // Scalar adder, shared by ADD/SUB and exported for the compare/address path
  logic        w_is_sub;
  logic [31:0] w_adder;
  assign w_is_sub = !bus.zpn_instr_i &&
                    (bus.alu_operator_i inside {ALU_SUB, ALU_SLT, ALU_SLTU});
  assign w_adder  = w_is_sub ? (w_a - w_b) : (w_a + w_b);

  // SMMWB split: a*b = (a_hi*b)<<16 + a_lo*b, so bits [47:16] equal
  // a_hi*b + (a_lo*b >>> 16) taken modulo 2^32.
  logic        w_smmwb;
  logic signed [33:0] w_part, w_hi, w_step;
  assign w_smmwb = bus.zpn_instr_i && (bus.zpn_operator_i == ZPN_SMMWB);
  assign w_part  = $signed({18'b0, w_a[15:0]}) *
                   $signed({{18{w_b[15]}}, w_b[15:0]});
  assign w_hi    = $signed({{18{w_a[31]}}, w_a[31:16]}) *
                   $signed({{18{w_b[15]}}, w_b[15:0]});
  assign w_step  = w_hi + ($signed(bus.imd_val_q_i[0]) >>> 16);

  // Leaving SMMWB or dropping mult_en_i aborts back to IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          mult_state_q <= IDLE;
    else if (!bus.mult_en_i || !w_smmwb)  mult_state_q <= IDLE;
    else if (mult_state_q == IDLE)        mult_state_q <= STEP1;
    else                                  mult_state_q <= IDLE;
  end

  always_comb begin
    bus.result_o            = '0;
    bus.valid_o             = 1'b1;
    bus.set_ov_o            = 1'b0;
    bus.comparison_result_o = 1'b0;
    bus.imd_val_d_o         = '0;
    bus.imd_val_we_o        = 2'b00;
    if (bus.zpn_instr_i) begin
      // Lane module already returns 0 for ops it does not own
      bus.result_o = {w_l16[1], w_l16[0]};
      bus.set_ov_o = |w_ov16;
      case (bus.zpn_operator_i)
        ZPN_ADD8: bus.result_o = w_add8;
        ZPN_SUB8: bus.result_o = w_sub8;
        ZPN_SMMWB: begin
          bus.result_o = '0;
          if (mult_state_q == IDLE) begin
            bus.valid_o         = 1'b0;
            bus.imd_val_d_o[0]  = w_part;
            // Suppress the write while reset is held
            bus.imd_val_we_o[0] = rst_ni & bus.mult_en_i;
          end else begin
            bus.result_o = w_step[31:0];
          end
        end
        default: ;
      endcase
    end else begin
      case (bus.alu_operator_i)
        ALU_ADD, ALU_SUB: bus.result_o = w_adder;
        ALU_SLT: begin
          bus.comparison_result_o = $signed(w_a) < $signed(w_b);
          bus.result_o            = {31'b0, bus.comparison_result_o};
        end
        ALU_SLTU: begin
          bus.comparison_result_o = w_a < w_b;
          bus.result_o            = {31'b0, bus.comparison_result_o};
        end
        default: ;
      endcase
    end
  end

  assign bus.adder_result_o = w_adder;

  logic unused_in;
  assign unused_in = ^{bus.multdiv_operator_i, bus.signed_mode_i, bus.div_en_i,
                       bus.div_sel_i, bus.data_ind_timing_i, bus.multdiv_sel_i,
                       bus.mult_sel_i, bus.multdiv_ready_id_i,
                       bus.imd_val_q_i[1], bus.operand_rd_i, bus.imm_val_i[4],
                       w_step[33:32]};
endmodule

// File: tb/tb_ibex_pext_alu.sv
// Self-checking bench for ibex_pext_alu: directed literal vectors plus a
// randomized run, all compared against an arithmetic reference model.
// The bench also plays the core's imd_val[0] register.

module tb_ibex_pext_alu;
  import ibex_pkg::*;
  import ibex_pkg_pext::*;

  logic clk_i, rst_ni;
  ibex_pext_alu_if bus();

  ibex_pext_alu dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [33:0] r_imd0 = '0;
  always @(posedge clk_i) if (bus.imd_val_we_o[0]) r_imd0 <= bus.imd_val_d_o[0];
  assign bus.imd_val_q_i = {34'b0, r_imd0};

  int n_chk = 0, n_err = 0;
  int exp_phase = 0;
  logic chk_on = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        valid, ov, cmp;
    logic [31:0] adder;
    logic [1:0]  we;
    logic [33:0] d0;
    logic        chk_res, chk_d0;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic per lane.
  // ph = which cycle of a two-cycle SMMWB the stimulus is in.
  function automatic exp_t model(input logic zpn, input zpn_op_e zop, input alu_op_e aop,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] imm, input logic men, input int ph,
                                 input logic rst);
    exp_t e;
    int sa, sb, s;
    longint bs, lo, p, full, tmp;
    logic [31:0] r;
    e.res = '0; e.valid = 1'b1; e.ov = 1'b0; e.cmp = 1'b0; e.we = 2'b00;
    e.d0 = '0; e.chk_res = 1'b1; e.chk_d0 = 1'b0;
    e.adder = (!zpn && (aop == ALU_SUB || aop == ALU_SLT || aop == ALU_SLTU)) ? a - b : a + b;
    r = '0;
    if (!zpn) begin
      case (aop)
        ALU_ADD:  r = a + b;
        ALU_SUB:  r = a - b;
        ALU_SLT:  begin e.cmp = ($signed(a) < $signed(b)); r = {31'b0, e.cmp}; end
        ALU_SLTU: begin e.cmp = (a < b); r = {31'b0, e.cmp}; end
        default:  r = '0;
      endcase
    end else if (zop == ZPN_SMMWB) begin
      bs = $signed(b[15:0]);
      if (ph == 0 || !rst) begin
        e.valid = 1'b0; e.chk_res = 1'b0;
        if (rst && men) begin
          lo = a[15:0];
          p = lo * bs;
          e.we = 2'b01; e.d0 = p[33:0]; e.chk_d0 = 1'b1;
        end
      end else begin
        full = longint'($signed(a)) * bs;
        tmp = full >>> 16;
        r = tmp[31:0];
      end
    end else if (zop == ZPN_ADD8 || zop == ZPN_SUB8) begin
      for (int i = 0; i < 4; i++)
        r[8*i +: 8] = (zop == ZPN_ADD8) ? a[8*i +: 8] + b[8*i +: 8] : a[8*i +: 8] - b[8*i +: 8];
    end else begin
      for (int i = 0; i < 2; i++) begin
        sa = $signed(a[16*i +: 16]);
        sb = $signed(b[16*i +: 16]);
        case (zop)
          ZPN_ADD16:  s = sa + sb;
          ZPN_SUB16:  s = sa - sb;
          ZPN_RADD16: s = (sa + sb) >>> 1;
`ifdef IBEX_PEXT_SAT_EN
          ZPN_KADD16, ZPN_KSUB16: begin
            s = (zop == ZPN_KADD16) ? sa + sb : sa - sb;
            if (s > 32767)       begin s = 32767;  e.ov = 1'b1; end
            else if (s < -32768) begin s = -32768; e.ov = 1'b1; end
          end
`endif
          ZPN_SRA16:  s = sa >>> imm[3:0];
          ZPN_SLL16:  s = sa << imm[3:0];
          default:    s = 0;
        endcase
        r[16*i +: 16] = s[15:0];
      end
    end
    e.res = r;
    return e;
  endfunction

  // Single compare process: every cycle with checking enabled
  always @(negedge clk_i) begin
    if (chk_on) begin
      exp_t e;
      e = model(bus.zpn_instr_i, bus.zpn_operator_i, bus.alu_operator_i, bus.operand_a_i,
                bus.operand_b_i, bus.imm_val_i, bus.mult_en_i, exp_phase, rst_ni);
      chk("valid", bus.valid_o, e.valid);
      if (e.chk_res) chk("result", bus.result_o, e.res);
      chk("set_ov", bus.set_ov_o, e.ov);
      chk("cmp", bus.comparison_result_o, e.cmp);
      chk("adder", bus.adder_result_o, e.adder);
      chk("imd_we", bus.imd_val_we_o, e.we);
      chk("imd_d1", bus.imd_val_d_o[1], 34'b0);
      if (e.chk_d0) chk("imd_d0", bus.imd_val_d_o[0], e.d0);
    end
  end

  task automatic drive(input logic zpn, input zpn_op_e zop, input alu_op_e aop,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] imm,
                       input logic men, input int ph);
    bus.zpn_instr_i = zpn; bus.zpn_operator_i = zop; bus.alu_operator_i = aop;
    bus.operand_a_i = a; bus.operand_b_i = b; bus.imm_val_i = imm;
    bus.mult_en_i = men; exp_phase = ph; chk_on = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic adv();
    @(posedge clk_i); #1;
  endtask

  task automatic zop_t(input zpn_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] imm);
    drive(1'b1, op, ZPN_INSTR, a, b, imm, 1'b0, 0);
  endtask

  task automatic smmwb_pair(input logic [31:0] a, input logic [31:0] b, input logic hold);
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, a, b, 5'd0, 1'b1, 0); adv();
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, a, b, 5'd0, 1'b1, 1);
    if (!hold) begin adv(); zop_t(ZPN_ADD16, a, b, 5'd0); end
    adv();
  endtask

  initial begin
    logic [31:0] ra, rb;
    int k;
    bus.multdiv_operator_i = MD_OP_MULL; bus.signed_mode_i = 2'b00;
    bus.div_en_i = 0; bus.div_sel_i = 0; bus.data_ind_timing_i = 0;
    bus.multdiv_sel_i = 0; bus.mult_sel_i = 0; bus.multdiv_ready_id_i = 1;
    bus.operand_rd_i = 32'h0; bus.mult_en_i = 0; bus.zpn_instr_i = 0;
    bus.zpn_operator_i = ZPN_ADD16; bus.alu_operator_i = ALU_ADD;
    bus.operand_a_i = 0; bus.operand_b_i = 0; bus.imm_val_i = 0;
    rst_ni = 1'b0;
    adv();

    // Reset with SMMWB requested: no valid, no imd write, no overflow
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, 32'hfffff7ff, 32'h7fffffbf, 5'd0, 1'b1, 0);
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_we", bus.imd_val_we_o, 2'b00);
    chk("rst_ov", bus.set_ov_o, 1'b0);
    adv();
    zop_t(ZPN_ADD16, 32'h0, 32'h0, 5'd0);
    adv();
    rst_ni = 1'b1;

    // SMMWB directed vector
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, 32'hfffff7ff, 32'h7fffffbf, 5'd0, 1'b1, 0);
    chk("smmwb_c0_valid", bus.valid_o, 1'b0);
    chk("smmwb_c0_we", bus.imd_val_we_o, 2'b01);
    adv();
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, 32'hfffff7ff, 32'h7fffffbf, 5'd0, 1'b1, 1);
    chk("smmwb_c1_valid", bus.valid_o, 1'b1);
    chk("smmwb_c1_res", bus.result_o, 32'h00000002);
    adv();

    zop_t(ZPN_ADD16, 32'h7fff0001, 32'h00010001, 5'd0);
    chk("add16", bus.result_o, 32'h80000002);
    chk("add16_ov", bus.set_ov_o, 1'b0);
    adv();
    zop_t(ZPN_KADD16, 32'h7fff8000, 32'h00018000, 5'd0);
`ifdef IBEX_PEXT_SAT_EN
    chk("kadd16", bus.result_o, 32'h7fff8000);
    chk("kadd16_ov", bus.set_ov_o, 1'b1);
`else
    chk("kadd16_off", bus.result_o, 32'h00000000);
    chk("kadd16_off_ov", bus.set_ov_o, 1'b0);
`endif
    adv();
    zop_t(ZPN_ADD8, 32'hff7f0102, 32'h01010101, 5'd0);
    chk("add8", bus.result_o, 32'h00800203);
    adv();
    zop_t(ZPN_SRA16, 32'h80000010, 32'h0, 5'd4);
    chk("sra16", bus.result_o, 32'hf8000001);
    adv();
    zop_t(ZPN_SLL16, 32'h80000010, 32'h0, 5'd4);
    chk("sll16", bus.result_o, 32'h00000100);
    adv();
    zop_t(ZPN_RADD16, 32'h7fff8000, 32'h7fff8000, 5'd0);
    chk("radd16", bus.result_o, 32'h7fff8000);
    adv();
    zop_t(ZPN_CRAS16, 32'h12345678, 32'h9abcdef0, 5'd0);
    chk("unsupported", bus.result_o, 32'h0);
    adv();
    drive(1'b0, ZPN_ADD16, ALU_SLT, 32'hffffffff, 32'h00000001, 5'd0, 1'b0, 0);
    chk("slt", bus.comparison_result_o, 1'b1);
    adv();
    drive(1'b0, ZPN_ADD16, ALU_SLTU, 32'hffffffff, 32'h00000001, 5'd0, 1'b0, 0);
    chk("sltu", bus.comparison_result_o, 1'b0);
    chk("sltu_adder", bus.adder_result_o, 32'hfffffffe);
    adv();

    // Reset during STEP1 drops the partial; the op restarts from cycle 0
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, 32'h12345678, 32'h0000abcd, 5'd0, 1'b1, 0);
    adv();
    rst_ni = 1'b0;
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, 32'h12345678, 32'h0000abcd, 5'd0, 1'b1, 0);
    chk("rst_mid_valid", bus.valid_o, 1'b0);
    adv();
    rst_ni = 1'b1;
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, 32'h12345678, 32'h0000abcd, 5'd0, 1'b1, 0);
    chk("restart_valid", bus.valid_o, 1'b0);
    chk("restart_we", bus.imd_val_we_o, 2'b01);
    adv();
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, 32'h12345678, 32'h0000abcd, 5'd0, 1'b1, 1);
    adv();

    // Back-to-back SMMWB with mult_en_i held high
    smmwb_pair(32'h80000000, 32'h00008000, 1'b1);
    smmwb_pair(32'h7fffffff, 32'h00007fff, 1'b0);

    // Abort: mult_en_i drops after cycle 0, next SMMWB starts fresh
    drive(1'b1, ZPN_SMMWB, ZPN_INSTR, 32'hdeadbeef, 32'h0000cafe, 5'd0, 1'b1, 0);
    adv();
    zop_t(ZPN_SUB16, 32'h00008000, 32'h00000001, 5'd0);
    adv();
    smmwb_pair(32'hdeadbeef, 32'h0000cafe, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 7 == 0) ra = {ra[31:16], 16'h7fff};
      if (i % 11 == 0) rb = {16'h8000, rb[15:0]};
      k = $urandom_range(0, 9);
      if (k < 5) begin
        k = $urandom_range(0, 9);
        if (k == 9) k = 10;
        zop_t(zpn_op_e'(4'(k)), ra, rb, 5'($urandom_range(0, 31)));
        adv();
      end else if (k < 8) begin
        drive(1'b0, ZPN_ADD16, alu_op_e'(7'($urandom_range(0, 7))), ra, rb, 5'd0, 1'b0, 0);
        adv();
      end else begin
        smmwb_pair(ra, rb, 1'b0);
      end
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
